// File: rtl/fp_pkg.sv
// Shared single-precision field widths, constants, FSM state type and unpacked-float struct
// for the floating-point scaling units.
package fp_pkg;

    localparam int unsigned SIGN_W   = 1;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MANT_W   = 23;
    localparam int unsigned FP_W     = SIGN_W + EXP_W + MANT_W;
    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned EXP_MAX  = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } fp_state_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
        logic              is_zero;
        logic              is_sub;
        logic              is_inf;
        logic              is_nan;
    } fp_unpacked_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational IEEE-754 single split into sign/exponent/mantissa plus class flags.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [FP_W-1:0] word,
    output fp_unpacked_t    fp_c
);

    logic exp_all_zero;
    logic exp_all_ones;
    logic mant_zero;

    assign exp_all_zero = (word[FP_W-2 -: EXP_W] == '0);
    assign exp_all_ones = (word[FP_W-2 -: EXP_W] == EXP_W'(EXP_MAX));
    assign mant_zero    = (word[MANT_W-1:0] == '0);

    always_comb begin
        fp_c         = '0;
        fp_c.sign    = word[FP_W-1];
        fp_c.exp     = word[FP_W-2 -: EXP_W];
        fp_c.mant    = word[MANT_W-1:0];
        fp_c.is_zero = exp_all_zero &  mant_zero;
        fp_c.is_sub  = exp_all_zero & ~mant_zero;
        fp_c.is_inf  = exp_all_ones &  mant_zero;
        fp_c.is_nan  = exp_all_ones & ~mant_zero;
    end

endmodule

// File: rtl/fp_mul_pow2.sv
// Multi-cycle scaling of an IEEE-754 single by 2^n (n = signed datab[7:0]).
// Define FP_MUL_POW2_DENORM_EN to produce subnormal results by serial right shifting.
module fp_mul_pow2
    import fp_pkg::*;
#(
    parameter int unsigned SHIFT_MAX = 24
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clk_en,
    input  logic            start,
    input  logic [FP_W-1:0] dataa,
    input  logic [FP_W-1:0] datab,
    output logic            done,
    output logic [FP_W-1:0] result
);

    if (SHIFT_MAX < 1) begin : g_bad_shift_max
        $error("SHIFT_MAX must be at least 1");
    end

    fp_state_e         state_q;
    fp_state_e         state_d;
    logic [FP_W-1:0]   op_q;
    logic [EXP_W-1:0]  n_q;
    logic [FP_W-1:0]   pend_q;
    fp_unpacked_t      unp_c;
    logic signed [9:0] e_sum_c;
    logic [FP_W-1:0]   calc_res_c;
    logic              to_shift_c;
    logic              unused_datab_hi;

    assign unused_datab_hi = ^datab[FP_W-1:EXP_W];

    fp_unpack u_unpack (
        .word (op_q),
        .fp_c (unp_c)
    );

    // Biased exponent plus sign-extended scale, wide enough for -128..382.
    assign e_sum_c = $signed({2'b00, unp_c.exp}) + $signed({{2{n_q[EXP_W-1]}}, n_q});

    // Result class selection evaluated while in CALC.
    always_comb begin
        calc_res_c = '0;
        to_shift_c = 1'b0;
        if (unp_c.is_inf || unp_c.is_nan) begin
            calc_res_c = op_q;
        end else if (unp_c.is_zero || unp_c.is_sub) begin
            calc_res_c = {unp_c.sign, 31'b0};
        end else if (e_sum_c >= $signed(10'(EXP_MAX))) begin
            calc_res_c = {unp_c.sign, EXP_W'(EXP_MAX), 23'b0};
        end else if (e_sum_c >= 10'sd1) begin
            calc_res_c = {unp_c.sign, e_sum_c[EXP_W-1:0], unp_c.mant};
        end else begin
            calc_res_c = {unp_c.sign, 31'b0};
`ifdef FP_MUL_POW2_DENORM_EN
            to_shift_c = 1'b1;
`endif
        end
    end

`ifdef FP_MUL_POW2_DENORM_EN
    localparam int unsigned CNT_W = $clog2(SHIFT_MAX + 1);

    logic [CNT_W-1:0]  cnt_q;
    logic [MANT_W:0]   sig_q;
    logic              kill_q;
    logic [9:0]        shift_amt_c;
    logic              last_shift_c;
    logic [FP_W-1:0]   denorm_res_c;

    assign shift_amt_c  = 10'(10'sd1 - e_sum_c);
    assign last_shift_c = (cnt_q == CNT_W'(1));
    // Value of the word once the final shift of this cycle has been applied.
    assign denorm_res_c = kill_q ? {unp_c.sign, 31'b0}
                                 : {unp_c.sign, 8'h00, sig_q[MANT_W:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            sig_q  <= '0;
            kill_q <= 1'b0;
        end else if (clk_en) begin
            if (state_q == CALC && to_shift_c) begin
                sig_q <= {1'b1, unp_c.mant};
                if (shift_amt_c >= 10'(SHIFT_MAX)) begin
                    cnt_q  <= CNT_W'(SHIFT_MAX);
                    kill_q <= 1'b1;
                end else begin
                    cnt_q  <= CNT_W'(shift_amt_c);
                    kill_q <= 1'b0;
                end
            end else if (state_q == SHIFT) begin
                sig_q <= sig_q >> 1;
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = CALC;
            CALC:  state_d = to_shift_c ? SHIFT : DONE;
`ifdef FP_MUL_POW2_DENORM_EN
            SHIFT: if (last_shift_c) state_d = DONE;
`else
            SHIFT: state_d = DONE;
`endif
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, operand latches and registered outputs; everything holds while clk_en is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            n_q     <= '0;
            pend_q  <= '0;
            done    <= 1'b0;
            result  <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            done    <= (state_q == DONE);
            if (state_q == IDLE && start) begin
                op_q <= dataa;
                n_q  <= datab[EXP_W-1:0];
            end
            if (state_q == CALC) begin
                pend_q <= calc_res_c;
            end
`ifdef FP_MUL_POW2_DENORM_EN
            if (state_q == SHIFT && last_shift_c) begin
                pend_q <= denorm_res_c;
            end
`endif
            if (state_q == DONE) begin
                result <= pend_q;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_pow2.sv
// Directed bench for fp_mul_pow2 with an arithmetic reference model and per-cycle output compare.
// Expectations follow FP_MUL_POW2_DENORM_EN when it is defined for the build.
module tb_fp_mul_pow2;

    localparam int unsigned SHIFT_MAX = 24;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic        done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_err = 0;
    bit check_on = 1'b0;

    fp_mul_pow2 #(.SHIFT_MAX(SHIFT_MAX)) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .dataa  (dataa),
        .datab  (datab),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %h, required %h at %0t", name, got, want, $time);
        end
    endfunction

    // Reference: scale by 2^n from the IEEE field rules; returns result word and cycles to done.
    function automatic void model_calc(input logic [31:0] a, input logic [7:0] n,
                                       output logic [31:0] r, output int lat);
        int e;
        int k;
        logic [23:0] sig;
        e   = int'(a[30:23]) + int'($signed(n));
        lat = 2;
        if (a[30:23] == 8'd255)      r = a;
        else if (a[30:23] == 8'd0)   r = {a[31], 31'b0};
        else if (e >= 255)           r = {a[31], 8'hFF, 23'b0};
        else if (e >= 1)             r = {a[31], e[7:0], a[22:0]};
        else begin
`ifdef FP_MUL_POW2_DENORM_EN
            k = 1 - e;
            if (k >= int'(SHIFT_MAX)) begin
                k = int'(SHIFT_MAX);
                r = {a[31], 31'b0};
            end else begin
                sig = {1'b1, a[22:0]} >> k;
                r   = {a[31], 8'h00, sig[22:0]};
            end
            lat = 2 + k;
`else
            k = 0;
            r = {a[31], 31'b0};
`endif
        end
    endfunction

    // Cycle-level expectation: an accepted request completes `lat` enabled edges later.
    logic        m_busy;
    int          m_cnt;
    logic [31:0] m_val;
    logic        exp_done;
    logic [31:0] exp_result;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy     = 1'b0;
            m_cnt      = 0;
            exp_done   = 1'b0;
            exp_result = 32'h0;
        end else if (clk_en) begin
            exp_done = 1'b0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    exp_done   = 1'b1;
                    exp_result = m_val;
                    m_busy     = 1'b0;
                end
            end else if (start) begin
                model_calc(dataa, datab[7:0], m_val, m_cnt);
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (check_on) begin
            check("done_cyc", 32'(done), 32'(exp_done));
            check("result_cyc", result, exp_result);
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [7:0]  n;
        logic [31:0] r;
        int          lat;
        int          stall;
        bit          poke;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [31:0] a, input logic [7:0] n,
                                input logic [31:0] r_den, input int lat_den,
                                input logic [31:0] r_nd, input int lat_nd,
                                input int stall_den, input bit poke);
        vec_t v;
        v.a = a;
        v.n = n;
        v.poke = poke;
`ifdef FP_MUL_POW2_DENORM_EN
        v.r = r_den; v.lat = lat_den; v.stall = stall_den;
`else
        v.r = r_nd;  v.lat = lat_nd;  v.stall = 0;
`endif
        vecs.push_back(v);
    endfunction

    task automatic run_vec(input vec_t v);
        logic [31:0] mr;
        int          ml;
        int          cyc;
        bit          got;
        bit          stalled;
        model_calc(v.a, v.n, mr, ml);
        check("model_res", mr, v.r);
        check("model_lat", 32'(ml), 32'(v.lat));
        @(negedge clk);
        datab      = $urandom();
        datab[7:0] = v.n;
        dataa      = v.a;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0; got = 1'b0; stalled = 1'b0;
        while (!got && cyc < 200) begin
            if (v.stall > 0 && cyc == v.stall && !stalled) begin
                clk_en = 1'b0;
                repeat (5) @(posedge clk);
                #1 clk_en = 1'b1;
                cyc += 5;
                stalled = 1'b1;
            end
            if (v.poke && cyc == 1) begin
                start = 1'b1;
                dataa = 32'h3F800000;
                datab = 32'h0000_0010;
            end
            @(posedge clk);
            cyc++;
            #1 start = 1'b0;
            if (done) got = 1'b1;
        end
        check("latency", 32'(cyc), 32'(v.lat + (stalled ? 5 : 0)));
        check("result", result, v.r);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        clk_en = 1'b1;
        start  = 1'b0;
        dataa  = 32'h0;
        datab  = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_done", 32'(done), 32'h0);
        check("reset_result", result, 32'h0);
        reset    = 1'b0;
        check_on = 1'b1;

        //   a             n      denorm result  lat  no-denorm     lat stall poke
        add(32'h41A00000, 8'h01, 32'h42200000,  2, 32'h42200000, 2, 0, 1'b1);
        add(32'h3E200000, 8'h07, 32'h41A00000,  2, 32'h41A00000, 2, 0, 1'b0);
        add(32'h80000000, 8'h05, 32'h80000000,  2, 32'h80000000, 2, 0, 1'b0);
        add(32'h7F000000, 8'h02, 32'h7F800000,  2, 32'h7F800000, 2, 0, 1'b0);
        add(32'h7FC00000, 8'hFD, 32'h7FC00000,  2, 32'h7FC00000, 2, 0, 1'b0);
        add(32'hFF800000, 8'h01, 32'hFF800000,  2, 32'hFF800000, 2, 0, 1'b0);
        add(32'h00800000, 8'hFF, 32'h00400000,  3, 32'h00000000, 2, 0, 1'b0);
        add(32'h3F800000, 8'h80, 32'h00200000,  4, 32'h00000000, 2, 0, 1'b0);
        add(32'h00800000, 8'h80, 32'h00000000, 26, 32'h00000000, 2, 0, 1'b0);
        add(32'h00800000, 8'h80, 32'h00000000, 26, 32'h00000000, 2, 5, 1'b0);
        add(32'h00C00000, 8'hE9, 32'h00000001, 25, 32'h00000000, 2, 0, 1'b0);
        add(32'hC0400000, 8'hFF, 32'hBFC00000,  2, 32'hBFC00000, 2, 0, 1'b0);
        add(32'h00000001, 8'h0A, 32'h00000000,  2, 32'h00000000, 2, 0, 1'b0);
        add(32'h3F800000, 8'h7F, 32'h7F000000,  2, 32'h7F000000, 2, 0, 1'b0);
        add(32'h40000000, 8'h7F, 32'h7F800000,  2, 32'h7F800000, 2, 0, 1'b0);
        add(32'h3F800000, 8'h82, 32'h00800000,  2, 32'h00800000, 2, 0, 1'b0);
        add(32'h3F800000, 8'h81, 32'h00400000,  3, 32'h00000000, 2, 0, 1'b0);
        add(32'hBFC00000, 8'h81, 32'h80600000,  3, 32'h80000000, 2, 0, 1'b0);
        add(32'h41A00000, 8'h01, 32'h42200000,  2, 32'h42200000, 2, 0, 1'b0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset in the middle of an operation: outputs clear at once and the op never completes.
        @(negedge clk);
        dataa = 32'h00800000;
        datab = 32'h0000_0080;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef FP_MUL_POW2_DENORM_EN
        repeat (5) @(negedge clk);
`endif
        #2 reset = 1'b1;
        #1;
        check("async_reset_done", 32'(done), 32'h0);
        check("async_reset_result", result, 32'h0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        run_vec(vecs[0]);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
